iec_sd_arbiter: RTL

//  Sits directly downstream of the multi-drive IEC selector, on its per-drive SD block interface.

---
 rtl/iec_sd_pkg.sv | 36 +++
 rtl/iec_rr_pick.sv | 36 +++
 rtl/iec_sd_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/iec_sd_pkg.sv
// Shared definitions for the IEC SD block-request arbiter.
//   arb_state_t : arbiter FSM states
//   MAX_DRIVES  : hard upper bound on the number of drive channels
//   ndr_clamp   : folds a requested drive count into 1..MAX_DRIVES
//   wrap_inc    : drive index + 1, wrapping at the live drive count
package iec_sd_pkg;

   localparam int MAX_DRIVES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2
   } arb_state_t;

   function automatic int ndr_clamp(input int drives);
      if (drives < 1) begin
         return 1;
      end else if (drives > MAX_DRIVES) begin
         return MAX_DRIVES;
      end
      return drives;
   endfunction

   // Index arithmetic must wrap at the real drive count, not at 4,
   // so a 3-drive build goes 2 -> 0 rather than visiting index 3.
   function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int ndr);
      int nxt;
      nxt = int'(idx) + 1;
      if (nxt >= ndr) begin
         nxt = 0;
      end
      return 2'(nxt);
   endfunction

endpackage

// File: rtl/iec_rr_pick.sv
// Round-robin selector.
//   pending : per-drive request flags (entries at or above NDR are ignored)
//   ptr     : index that has highest priority this round (must be < NDR)
//   valid   : at least one drive among 0..NDR-1 is pending
//   idx     : first pending drive at or after ptr, modulo NDR
module iec_rr_pick
   import iec_sd_pkg::*;
#(
   parameter int NDR = MAX_DRIVES
) (
   input  logic [MAX_DRIVES-1:0] pending,
   input  logic [1:0]            ptr,
   output logic                  valid,
   output logic [1:0]            idx
);

   // Walk the ring starting at ptr; the first hit wins. ptr and k are both
   // below NDR, so a single conditional subtraction is enough to wrap.
   always_comb begin
      int j;
      valid = 1'b0;
      idx   = 2'd0;
      j     = 0;
      for (int k = 0; k < NDR; k++) begin
         j = int'(ptr) + k;
         if (j >= NDR) begin
            j = j - NDR;
         end
         if (!valid && pending[j[1:0]]) begin
            valid = 1'b1;
            idx   = j[1:0];
         end
      end
   end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Merges per-drive SD block requests onto one host virtual-disk port.
//   clk_sys, reset_n              : clock, asynchronous active-low reset
//   drv_lba/blk_cnt/rd/wr/buff_din: per-drive request interface
//   drv_ack                       : host_ack steered to the granted drive
//   host_lba/blk_cnt/rd/wr        : latched request toward the host
//   host_ack                      : host acknowledge, high for the transfer
//   host_buff_din                 : write data of the granted drive
//   grant                         : current or last granted drive
//   busy                          : FSM outside IDLE
//   timeout_err                   : one-cycle pulse on watchdog abort
module iec_sd_arbiter
   import iec_sd_pkg::*;
#(
   parameter  int DRIVES    = 2,
   parameter  int TIMEOUT_W = 24,
   localparam int NDR       = ndr_clamp(DRIVES)
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [NDR-1:0][31:0]  drv_lba,
   input  logic [NDR-1:0][5:0]   drv_blk_cnt,
   input  logic [NDR-1:0]        drv_rd,
   input  logic [NDR-1:0]        drv_wr,
   output logic [NDR-1:0]        drv_ack,
   input  logic [NDR-1:0][7:0]   drv_buff_din,
   output logic [31:0]           host_lba,
   output logic [5:0]            host_blk_cnt,
   output logic                  host_rd,
   output logic                  host_wr,
   input  logic                  host_ack,
   output logic [7:0]            host_buff_din,
   output logic [1:0]            grant,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam logic [TIMEOUT_W-1:0] WD_MAX  = {TIMEOUT_W{1'b1}};
   localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_MAX - TIMEOUT_W'(1);

   arb_state_t                    state, state_next;
   logic [TIMEOUT_W-1:0]          wd;
   logic [1:0]                    rr;
   logic [MAX_DRIVES-1:0]         rd4, wr4;
   logic [MAX_DRIVES-1:0][31:0]   lba4;
   logic [MAX_DRIVES-1:0][5:0]    blk4;
   logic [MAX_DRIVES-1:0][7:0]    din4;
   logic [1:0]                    pick_ptr, pick_idx;
   logic                          pick_valid;
   logic                          do_latch, do_clear, do_abort, rr_adv, wd_hit;

   // Pad the per-drive buses out to four entries so a 2-bit index can
   // select from them for any drive count; absent drives never request.
   for (genvar g = 0; g < MAX_DRIVES; g++) begin : g_pad
      if (g < NDR) begin : g_on
         assign rd4[g]  = drv_rd[g];
         assign wr4[g]  = drv_wr[g];
         assign lba4[g] = drv_lba[g];
         assign blk4[g] = drv_blk_cnt[g];
         assign din4[g] = drv_buff_din[g];
      end else begin : g_off
         assign rd4[g]  = 1'b0;
         assign wr4[g]  = 1'b0;
         assign lba4[g] = '0;
         assign blk4[g] = '0;
         assign din4[g] = '0;
      end
   end

   // Leaving XFER re-arbitrates in the same edge, so the pointer must
   // already be advanced past the finishing drive at that moment.
   assign pick_ptr = (state == XFER) ? wrap_inc(grant, NDR) : rr;

   iec_rr_pick #(
      .NDR (NDR)
   ) u_pick (
      .pending (rd4 | wr4),
      .ptr     (pick_ptr),
      .valid   (pick_valid),
      .idx     (pick_idx)
   );

   // host_rd/wr stays high for exactly 2**TIMEOUT_W-1 cycles before abort.
   assign wd_hit = (wd == WD_LAST);

   assign busy          = (state != IDLE);
   assign host_buff_din = din4[grant];

   // The ack must follow host_ack with no delay so it lines up with the
   // shared buffer write strobe the drives sample alongside it.
   for (genvar g = 0; g < NDR; g++) begin : g_ack
      assign drv_ack[g] = host_ack & busy & (grant == 2'(g));
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      do_latch   = 1'b0;
      do_clear   = 1'b0;
      do_abort   = 1'b0;
      rr_adv     = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               do_latch   = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (host_ack) begin
               do_clear   = 1'b1;
               state_next = XFER;
            end else if (wd_hit) begin
               do_clear   = 1'b1;
               do_abort   = 1'b1;
               rr_adv     = 1'b1;
               state_next = IDLE;
            end
         end
         XFER: begin
            if (!host_ack) begin
               rr_adv = 1'b1;
               if (pick_valid) begin
                  do_latch   = 1'b1;
                  state_next = REQ;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Read wins when a drive raises both; its write stays pending and is
   // picked up in a later round.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         grant        <= '0;
         host_lba     <= '0;
         host_blk_cnt <= '0;
         host_rd      <= 1'b0;
         host_wr      <= 1'b0;
         timeout_err  <= 1'b0;
         rr           <= '0;
         wd           <= '0;
      end else begin
         timeout_err <= do_abort;
         if (rr_adv) begin
            rr <= wrap_inc(grant, NDR);
         end
         if (do_latch) begin
            grant        <= pick_idx;
            host_lba     <= lba4[pick_idx];
            host_blk_cnt <= blk4[pick_idx];
            host_rd      <= rd4[pick_idx];
            host_wr      <= !rd4[pick_idx];
            wd           <= '0;
         end else begin
            if (do_clear) begin
               host_rd <= 1'b0;
               host_wr <= 1'b0;
            end
            if ((state == REQ) && (wd != WD_MAX)) begin
               wd <= wd + TIMEOUT_W'(1);
            end
         end
      end
   end

endmodule
